// File: rtl/uart_port_arbiter.sv
// uart_port_arbiter: shares one simpleuart data register between two transmit
// requesters and a periodic receive poller. Transmit requests are arbitrated
// round-robin; a poll timer periodically reads the data register and hands any
// received byte to the consumer through a valid/ready handshake.
module uart_port_arbiter #(
    parameter int unsigned POLL_DIV = 1250
) (
    input  logic        hw_clk,
    input  logic        resetn,
    // requester 0 transmit handshake
    input  logic        tx0_valid,
    input  logic [7:0]  tx0_data,
    output logic        tx0_ready,
    // requester 1 transmit handshake
    input  logic        tx1_valid,
    input  logic [7:0]  tx1_data,
    output logic        tx1_ready,
    // received-byte handshake toward the consumer
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    // simpleuart data-register port
    output logic        reg_dat_we,
    output logic        reg_dat_re,
    output logic [31:0] reg_dat_di,
    input  logic [31:0] reg_dat_do,
    input  logic        reg_dat_wait,
    output logic        busy
);

    localparam int unsigned   TW         = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(POLL_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        POLL  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          last_q, last_d;        // requester granted most recently
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic [31:0]   di_q, di_d;
    logic          tx0_ready_q, tx0_ready_d;
    logic          tx1_ready_q, tx1_ready_d;
    logic          rx_valid_q, rx_valid_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          busy_q, busy_d;

    logic          poll_due;
    logic          grant1;

    // Timer saturates at zero, so a due poll simply waits until it is allowed.
    assign poll_due = (timer_q == '0);

    // Requester 1 wins when it is alone, or when both ask and 0 was served last.
    assign grant1 = tx1_valid && (!tx0_valid || !last_q);

    // Next-state and registered-output logic for the arbiter FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        timer_d     = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
        last_d      = last_q;
        we_d        = we_q;
        re_d        = 1'b0;
        di_d        = di_q;
        tx0_ready_d = 1'b0;
        tx1_ready_d = 1'b0;
        rx_valid_d  = rx_valid_q && !rx_ready;
        rx_data_d   = rx_data_q;

        unique case (state_q)
            IDLE: begin
                // A poll wins over transmit, but never while a byte is still pending.
                if (poll_due && !rx_valid_q) begin
                    state_d = POLL;
                    re_d    = 1'b1;
                end else if (tx0_valid || tx1_valid) begin
                    state_d = WRITE;
                    last_d  = grant1;
                    we_d    = 1'b1;
                    di_d    = {24'h0, grant1 ? tx1_data : tx0_data};
                end
            end
            WRITE: begin
                // Hold the write until the UART stops stalling.
                if (!reg_dat_wait) begin
                    state_d     = DONE;
                    we_d        = 1'b0;
                    tx0_ready_d = !last_q;
                    tx1_ready_d = last_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            POLL: begin
                // All-ones read data means the receive buffer was empty.
                state_d = IDLE;
                timer_d = TIMER_LOAD;
                if (reg_dat_do != 32'hFFFF_FFFF) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = reg_dat_do[7:0];
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            timer_q     <= TIMER_LOAD;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            di_q        <= '0;
            tx0_ready_q <= 1'b0;
            tx1_ready_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            timer_q     <= timer_d;
            last_q      <= last_d;
            we_q        <= we_d;
            re_q        <= re_d;
            di_q        <= di_d;
            tx0_ready_q <= tx0_ready_d;
            tx1_ready_q <= tx1_ready_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            busy_q      <= busy_d;
        end
    end

    assign reg_dat_we = we_q;
    assign reg_dat_re = re_q;
    assign reg_dat_di = di_q;
    assign tx0_ready  = tx0_ready_q;
    assign tx1_ready  = tx1_ready_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed testbench for uart_port_arbiter. Instance a uses the default poll
// divider for transmit scenarios; instance b uses a divider of 4 for receive
// and poll-priority scenarios.
module tb_uart_port_arbiter;

    logic hw_clk;
    logic resetn;

    // instance a (POLL_DIV = 1250)
    logic        a_tx0_valid, a_tx1_valid, a_tx0_ready, a_tx1_ready;
    logic [7:0]  a_tx0_data, a_tx1_data, a_rx_data;
    logic        a_rx_valid, a_rx_ready, a_we, a_re, a_wait, a_busy;
    logic [31:0] a_di, a_do;

    // instance b (POLL_DIV = 4)
    logic        b_tx0_valid, b_tx1_valid, b_tx0_ready, b_tx1_ready;
    logic [7:0]  b_tx0_data, b_tx1_data, b_rx_data;
    logic        b_rx_valid, b_rx_ready, b_we, b_re, b_wait, b_busy;
    logic [31:0] b_di, b_do;

    int checks = 0;
    int errors = 0;

    uart_port_arbiter #(.POLL_DIV(1250)) dut_a (
        .hw_clk(hw_clk), .resetn(resetn),
        .tx0_valid(a_tx0_valid), .tx0_data(a_tx0_data), .tx0_ready(a_tx0_ready),
        .tx1_valid(a_tx1_valid), .tx1_data(a_tx1_data), .tx1_ready(a_tx1_ready),
        .rx_valid(a_rx_valid), .rx_data(a_rx_data), .rx_ready(a_rx_ready),
        .reg_dat_we(a_we), .reg_dat_re(a_re), .reg_dat_di(a_di),
        .reg_dat_do(a_do), .reg_dat_wait(a_wait), .busy(a_busy)
    );

    uart_port_arbiter #(.POLL_DIV(4)) dut_b (
        .hw_clk(hw_clk), .resetn(resetn),
        .tx0_valid(b_tx0_valid), .tx0_data(b_tx0_data), .tx0_ready(b_tx0_ready),
        .tx1_valid(b_tx1_valid), .tx1_data(b_tx1_data), .tx1_ready(b_tx1_ready),
        .rx_valid(b_rx_valid), .rx_data(b_rx_data), .rx_ready(b_rx_ready),
        .reg_dat_we(b_we), .reg_dat_re(b_re), .reg_dat_di(b_di),
        .reg_dat_do(b_do), .reg_dat_wait(b_wait), .busy(b_busy)
    );

    initial hw_clk = 1'b0;
    always #5 hw_clk = ~hw_clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge hw_clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_tx0_valid = 0; a_tx1_valid = 0; a_tx0_data = 8'h00; a_tx1_data = 8'h00;
        a_rx_ready  = 0; a_wait = 0; a_do = 32'hFFFF_FFFF;
        b_tx0_valid = 0; b_tx1_valid = 0; b_tx0_data = 8'h00; b_tx1_data = 8'h00;
        b_rx_ready  = 0; b_wait = 0; b_do = 32'hFFFF_FFFF;
    endtask

    // Hold reset across two edges, release just after an edge.
    task automatic apply_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge hw_clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b1;
        #2;
        resetn = 1'b0;
        #2;
        checks++; if ({a_we, a_re, a_tx0_ready, a_tx1_ready, a_rx_valid, a_busy} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                               {a_we, a_re, a_tx0_ready, a_tx1_ready, a_rx_valid, a_busy});
        end
        checks++; if (a_di !== 32'h0) begin
            errors++; $display("FAIL reset_di: got %h expected 00000000", a_di);
        end
        checks++; if (a_rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_rx_data: got %h expected 00", a_rx_data);
        end
        checks++; if ({b_we, b_re, b_rx_valid, b_busy} !== 4'b0) begin
            errors++; $display("FAIL reset_b_flags: got %b expected 0000", {b_we, b_re, b_rx_valid, b_busy});
        end
        apply_reset();
        tick();
        checks++; if ({a_busy, a_we, a_re} !== 3'b000) begin
            errors++; $display("FAIL reset_quiet: got %b expected 000", {a_busy, a_we, a_re});
        end
    endtask

    task automatic test_single_write();
        apply_reset();
        a_tx0_valid = 1; a_tx0_data = 8'h50; a_wait = 0;
        tick();
        checks++; if ({a_we, a_busy, a_tx0_ready} !== 3'b110 || a_di !== 32'h0000_0050) begin
            errors++; $display("FAIL single_write_grant: got we/busy/rdy=%b di=%h expected 110 di=00000050",
                               {a_we, a_busy, a_tx0_ready}, a_di);
        end
        tick();
        checks++; if ({a_we, a_busy, a_tx0_ready, a_tx1_ready} !== 4'b0110) begin
            errors++; $display("FAIL single_write_done: got we/busy/rdy0/rdy1=%b expected 0110",
                               {a_we, a_busy, a_tx0_ready, a_tx1_ready});
        end
        a_tx0_valid = 0;
        tick();
        checks++; if ({a_we, a_busy, a_tx0_ready} !== 3'b000) begin
            errors++; $display("FAIL single_write_idle: got %b expected 000", {a_we, a_busy, a_tx0_ready});
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        a_tx0_valid = 1; a_tx0_data = 8'h50; a_wait = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({a_we, a_tx0_ready} !== 2'b10 || a_di !== 32'h0000_0050) begin
                errors++; $display("FAIL backpressure_hold[%0d]: got we/rdy=%b di=%h expected 10 di=00000050",
                                   i, {a_we, a_tx0_ready}, a_di);
            end
        end
        a_wait = 0;
        tick();
        checks++; if ({a_we, a_tx0_ready, a_busy} !== 3'b011) begin
            errors++; $display("FAIL backpressure_accept: got we/rdy/busy=%b expected 011",
                               {a_we, a_tx0_ready, a_busy});
        end
        a_tx0_valid = 0;
        tick();
        checks++; if ({a_tx0_ready, a_busy} !== 2'b00) begin
            errors++; $display("FAIL backpressure_end: got rdy/busy=%b expected 00", {a_tx0_ready, a_busy});
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_di;
        logic [1:0]  exp_rdy;
        apply_reset();
        a_tx0_valid = 1; a_tx0_data = 8'h31;
        a_tx1_valid = 1; a_tx1_data = 8'h32;
        for (int k = 0; k < 4; k++) begin
            exp_di  = (k % 2 == 0) ? 32'h0000_0031 : 32'h0000_0032;
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            checks++; if (a_we !== 1'b1 || a_di !== exp_di) begin
                errors++; $display("FAIL contention_grant[%0d]: got we=%b di=%h expected we=1 di=%h",
                                   k, a_we, a_di, exp_di);
            end
            tick();
            checks++; if ({a_tx1_ready, a_tx0_ready} !== exp_rdy) begin
                errors++; $display("FAIL contention_ready[%0d]: got rdy1/rdy0=%b expected %b",
                                   k, {a_tx1_ready, a_tx0_ready}, exp_rdy);
            end
            tick();
        end
        a_tx0_valid = 0; a_tx1_valid = 0;
    endtask

    task automatic test_receive();
        apply_reset();
        b_do = 32'h0000_0035; b_rx_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (b_re !== 1'b0) begin
                errors++; $display("FAIL receive_early_re[%0d]: got %b expected 0", i, b_re);
            end
        end
        tick();
        checks++; if ({b_re, b_we, b_busy} !== 3'b101) begin
            errors++; $display("FAIL receive_poll: got re/we/busy=%b expected 101", {b_re, b_we, b_busy});
        end
        tick();
        checks++; if ({b_re, b_rx_valid, b_busy} !== 3'b010 || b_rx_data !== 8'h35) begin
            errors++; $display("FAIL receive_capture: got re/vld/busy=%b data=%h expected 010 data=35",
                               {b_re, b_rx_valid, b_busy}, b_rx_data);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({b_re, b_rx_valid} !== 2'b01) begin
                errors++; $display("FAIL receive_blocked[%0d]: got re/vld=%b expected 01", i, {b_re, b_rx_valid});
            end
        end
        b_do = 32'h0000_01FF; b_rx_ready = 1;
        tick();
        checks++; if ({b_re, b_rx_valid} !== 2'b00) begin
            errors++; $display("FAIL receive_consume: got re/vld=%b expected 00", {b_re, b_rx_valid});
        end
        b_rx_ready = 0;
        tick();
        checks++; if (b_re !== 1'b1) begin
            errors++; $display("FAIL receive_resume: got re=%b expected 1", b_re);
        end
        tick();
        checks++; if (b_rx_valid !== 1'b1 || b_rx_data !== 8'hFF) begin
            errors++; $display("FAIL receive_low_byte: got vld=%b data=%h expected vld=1 data=ff",
                               b_rx_valid, b_rx_data);
        end
    endtask

    task automatic test_empty_poll_priority();
        apply_reset();
        b_do = 32'hFFFF_FFFF; b_tx1_data = 8'h32;
        repeat (3) tick();
        b_tx1_valid = 1;
        tick();
        checks++; if ({b_re, b_we, b_busy} !== 3'b101) begin
            errors++; $display("FAIL priority_poll_first: got re/we/busy=%b expected 101", {b_re, b_we, b_busy});
        end
        tick();
        checks++; if ({b_re, b_we, b_rx_valid, b_busy} !== 4'b0000) begin
            errors++; $display("FAIL priority_empty_poll: got re/we/vld/busy=%b expected 0000",
                               {b_re, b_we, b_rx_valid, b_busy});
        end
        tick();
        checks++; if ({b_re, b_we} !== 2'b01 || b_di !== 32'h0000_0032) begin
            errors++; $display("FAIL priority_tx1_grant: got re/we=%b di=%h expected 01 di=00000032",
                               {b_re, b_we}, b_di);
        end
        tick();
        checks++; if ({b_tx1_ready, b_tx0_ready, b_we} !== 3'b100) begin
            errors++; $display("FAIL priority_tx1_ready: got rdy1/rdy0/we=%b expected 100",
                               {b_tx1_ready, b_tx0_ready, b_we});
        end
        b_tx1_valid = 0;
        tick();
        checks++; if ({b_tx1_ready, b_busy} !== 2'b00) begin
            errors++; $display("FAIL priority_end: got rdy1/busy=%b expected 00", {b_tx1_ready, b_busy});
        end
    endtask

    task automatic test_reset_abort();
        apply_reset();
        a_tx0_valid = 1; a_tx0_data = 8'h50; a_wait = 1;
        repeat (2) tick();
        checks++; if (a_we !== 1'b1) begin
            errors++; $display("FAIL abort_in_write: got we=%b expected 1", a_we);
        end
        resetn = 1'b0;
        #1;
        checks++; if ({a_we, a_busy, a_tx0_ready} !== 3'b000 || a_di !== 32'h0) begin
            errors++; $display("FAIL abort_async: got we/busy/rdy=%b di=%h expected 000 di=00000000",
                               {a_we, a_busy, a_tx0_ready}, a_di);
        end
        a_wait = 0;
        tick();
        checks++; if ({a_we, a_tx0_ready, a_tx1_ready} !== 3'b000) begin
            errors++; $display("FAIL abort_no_ready: got we/rdy0/rdy1=%b expected 000",
                               {a_we, a_tx0_ready, a_tx1_ready});
        end
        resetn = 1'b1;
        tick();
        checks++; if (a_we !== 1'b1 || a_di !== 32'h0000_0050) begin
            errors++; $display("FAIL abort_regrant: got we=%b di=%h expected we=1 di=00000050", a_we, a_di);
        end
        tick();
        checks++; if (a_tx0_ready !== 1'b1) begin
            errors++; $display("FAIL abort_regrant_ready: got %b expected 1", a_tx0_ready);
        end
        a_tx0_valid = 0;
        tick();
    endtask

    initial begin
        resetn = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_backpressure();
        test_contention();
        test_receive();
        test_empty_poll_priority();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
